// File: rtl/wishbone_slave_decoder_2.sv
// wishbone_slave_decoder_2: routes one Wishbone master to two slaves by upper address byte, with a no-ack watchdog and an error response.
module wishbone_slave_decoder_2 #(
   parameter logic [7:0]  S0_BASE = 8'h00,
   parameter logic [7:0]  S1_BASE = 8'h01,
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_we_i,
   input  logic        m_cyc_i,
   input  logic        m_stb_i,
   input  logic [3:0]  m_sel_i,
   input  logic [31:0] m_adr_i,
   input  logic [31:0] m_dat_i,
   output logic [31:0] m_dat_o,
   output logic        m_ack_o,
   output logic        m_err_o,
   output logic        m_int_o,
   output logic        s0_we_o,
   output logic        s0_cyc_o,
   output logic        s0_stb_o,
   output logic [3:0]  s0_sel_o,
   output logic [31:0] s0_adr_o,
   output logic [31:0] s0_dat_o,
   input  logic        s0_ack_i,
   input  logic [31:0] s0_dat_i,
   input  logic        s0_int_i,
   output logic        s1_we_o,
   output logic        s1_cyc_o,
   output logic        s1_stb_o,
   output logic [3:0]  s1_sel_o,
   output logic [31:0] s1_adr_o,
   output logic [31:0] s1_dat_o,
   input  logic        s1_ack_i,
   input  logic [31:0] s1_dat_i,
   input  logic        s1_int_i
);
   typedef enum logic [2:0] {IDLE, SEL0, SEL1, ERR, DRAIN} state_t;
   state_t state, nxt;
   logic [15:0] wd;
   logic [7:0] hi;
   logic go0, go1, ack, tmo, hold;
   assign hi = m_adr_i[31:24];
   // a strobe that decodes elsewhere kills routing in the same cycle so the wrong slave never sees it
   always_comb begin
      go0 = state == SEL0 && !(m_stb_i && hi != S0_BASE);
      go1 = state == SEL1 && !(m_stb_i && hi != S1_BASE);
      ack = go0 ? s0_ack_i : go1 ? s1_ack_i : 1'b0;
      tmo = (go0 | go1) & m_stb_i & ~ack & (wd == TIMEOUT - 16'd1);
      nxt = state;
      case (state)
         IDLE:       if (m_cyc_i & m_stb_i) nxt = hi == S0_BASE ? SEL0 : hi == S1_BASE ? SEL1 : ERR;
         SEL0, SEL1: nxt = !m_cyc_i ? IDLE : (!(go0 | go1) || tmo) ? ERR : state;
         ERR:        nxt = m_cyc_i ? DRAIN : IDLE;
         DRAIN:      nxt = m_cyc_i ? DRAIN : IDLE;
         default:    nxt = IDLE;
      endcase
      hold = (go0 | go1) & m_stb_i & ~ack & (nxt == state);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         wd      <= 16'd0;
         m_err_o <= 1'b0;
      end else begin
         state   <= nxt;
         wd      <= hold ? wd + 16'd1 : 16'd0;
         m_err_o <= nxt == ERR;
      end
   end
   assign s0_we_o  = go0 & m_we_i;
   assign s0_cyc_o = go0 & m_cyc_i;
   assign s0_stb_o = go0 & m_stb_i;
   assign s0_sel_o = go0 ? m_sel_i : 4'h0;
   assign s0_adr_o = go0 ? {8'h00, m_adr_i[23:0]} : 32'h0;
   assign s0_dat_o = go0 ? m_dat_i : 32'h0;
   assign s1_we_o  = go1 & m_we_i;
   assign s1_cyc_o = go1 & m_cyc_i;
   assign s1_stb_o = go1 & m_stb_i;
   assign s1_sel_o = go1 ? m_sel_i : 4'h0;
   assign s1_adr_o = go1 ? {8'h00, m_adr_i[23:0]} : 32'h0;
   assign s1_dat_o = go1 ? m_dat_i : 32'h0;
   assign m_ack_o  = ack;
   assign m_dat_o  = go0 ? s0_dat_i : go1 ? s1_dat_i : 32'h0;
   assign m_int_o  = s0_int_i | s1_int_i;
endmodule

// File: tb/tb_wishbone_slave_decoder_2.sv
// tb_wishbone_slave_decoder_2: directed and randomized bus traffic checked against a transaction-level model of the decoder.
module tb_wishbone_slave_decoder_2;
   localparam int TO = 16;
   logic clk, rst;
   logic m_we_i, m_cyc_i, m_stb_i;
   logic [3:0] m_sel_i;
   logic [31:0] m_adr_i, m_dat_i, m_dat_o;
   logic m_ack_o, m_err_o, m_int_o;
   logic s0_we_o, s0_cyc_o, s0_stb_o, s0_ack_i, s0_int_i;
   logic [3:0] s0_sel_o;
   logic [31:0] s0_adr_o, s0_dat_o, s0_dat_i;
   logic s1_we_o, s1_cyc_o, s1_stb_o, s1_ack_i, s1_int_i;
   logic [3:0] s1_sel_o;
   logic [31:0] s1_adr_o, s1_dat_o, s1_dat_i;
   int n_checks = 0, n_errors = 0;
   int owner, stall;
   bit err_now, draining;
   wishbone_slave_decoder_2 #(.S0_BASE(8'h00), .S1_BASE(8'h01), .TIMEOUT(16'(TO))) dut (
      .clk(clk), .rst(rst),
      .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .m_int_o(m_int_o),
      .s0_we_o(s0_we_o), .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_sel_o(s0_sel_o),
      .s0_adr_o(s0_adr_o), .s0_dat_o(s0_dat_o), .s0_ack_i(s0_ack_i), .s0_dat_i(s0_dat_i), .s0_int_i(s0_int_i),
      .s1_we_o(s1_we_o), .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_sel_o(s1_sel_o),
      .s1_adr_o(s1_adr_o), .s1_dat_o(s1_dat_o), .s1_ack_i(s1_ack_i), .s1_dat_i(s1_dat_i), .s1_int_i(s1_int_i)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic int dec(input logic [31:0] a);
      return a[31:24] == 8'h00 ? 0 : a[31:24] == 8'h01 ? 1 : -1;
   endfunction
   function automatic void model_reset();
      owner = -1; stall = 0; err_now = 0; draining = 0;
   endfunction
   // compare every output against the model for the current cycle, then advance the model across the edge
   task automatic tick();
      logic [70:0] pass, s0b, s1b;
      bit hit, a;
      #2;
      hit  = owner >= 0 && !(m_stb_i && dec(m_adr_i) != owner);
      a    = !hit ? 1'b0 : owner == 0 ? s0_ack_i : s1_ack_i;
      pass = {m_we_i, m_cyc_i, m_stb_i, m_sel_i, {8'h00, m_adr_i[23:0]}, m_dat_i};
      s0b  = {s0_we_o, s0_cyc_o, s0_stb_o, s0_sel_o, s0_adr_o, s0_dat_o};
      s1b  = {s1_we_o, s1_cyc_o, s1_stb_o, s1_sel_o, s1_adr_o, s1_dat_o};
      check("s0_bus", s0b, (hit && owner == 0) ? pass : 71'd0);
      check("s1_bus", s1b, (hit && owner == 1) ? pass : 71'd0);
      check("m_ack", m_ack_o, a);
      check("m_dat", m_dat_o, !hit ? 32'd0 : owner == 0 ? s0_dat_i : s1_dat_i);
      check("m_err", m_err_o, err_now);
      check("m_int", m_int_o, s0_int_i | s1_int_i);
      if (err_now) begin
         err_now = 0; draining = m_cyc_i; owner = -1; stall = 0;
      end else if (draining) begin
         draining = m_cyc_i;
      end else if (owner < 0) begin
         if (m_cyc_i && m_stb_i) begin
            if (dec(m_adr_i) < 0) err_now = 1;
            else owner = dec(m_adr_i);
         end
      end else if (!m_cyc_i) begin
         owner = -1; stall = 0;
      end else if (!hit) begin
         err_now = 1; owner = -1; stall = 0;
      end else if (m_stb_i && !a) begin
         if (stall == TO - 1) begin
            err_now = 1; owner = -1; stall = 0;
         end else stall++;
      end else stall = 0;
      @(posedge clk); #1;
   endtask
   task automatic bus(input bit cyc, input bit stb, input bit we, input logic [31:0] adr);
      m_cyc_i = cyc; m_stb_i = stb; m_we_i = we; m_adr_i = adr;
      m_sel_i = 4'($urandom); m_dat_i = $urandom;
   endtask
   initial begin
      int rate;
      rst = 1'b0; model_reset();
      bus(1, 1, 1, 32'h0000_0040);
      s0_ack_i = 1; s1_ack_i = 1; s0_dat_i = $urandom; s1_dat_i = $urandom; s0_int_i = 0; s1_int_i = 0;
      #2;
      check("rst_s0", {s0_cyc_o, s0_stb_o, s0_adr_o}, 0);
      check("rst_s1", {s1_cyc_o, s1_stb_o, s1_adr_o}, 0);
      check("rst_m", {m_ack_o, m_err_o, m_dat_o}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      bus(0, 0, 0, 0); tick();
      // single read to slave 0, acked in its first strobe cycle
      bus(1, 1, 0, 32'h0000_0010); s0_dat_i = 32'hDEADBEEF; s0_ack_i = 1; tick();
      #1;
      check("rd_stb", s0_stb_o, 1'b1);
      check("rd_adr", s0_adr_o, 32'h0000_0010);
      check("rd_dat", {m_ack_o, m_dat_o}, {1'b1, 32'hDEADBEEF});
      tick();
      bus(0, 0, 0, 0); tick(); tick();
      // four-beat block write to slave 1
      s1_ack_i = 1;
      bus(1, 1, 1, 32'h0100_0000); tick();
      for (int i = 0; i < 4; i++) begin
         bus(1, 1, 1, 32'h0100_0000 + 32'(4 * i));
         #1; check("blk_ack", {m_ack_o, s1_adr_o[31:24]}, {1'b1, 8'h00});
         tick();
      end
      bus(0, 0, 0, 0); tick(); tick();
      // unmapped address, then a strobe while draining
      bus(1, 1, 0, 32'h0500_0000); tick();
      #1; check("unm_err", m_err_o, 1'b1);
      tick();
      bus(1, 1, 0, 32'h0000_0000); tick(); tick();
      bus(0, 0, 0, 0); tick(); tick();
      // watchdog expiry with slave 0 silent
      s0_ack_i = 0;
      bus(1, 1, 0, 32'h0000_0000); tick();
      for (int i = 0; i < TO; i++) tick();
      #1; check("to_err", {m_err_o, s0_stb_o}, 2'b10);
      tick();
      bus(0, 0, 0, 0); tick(); tick();
      // ack on the last watchdog cycle wins
      bus(1, 1, 0, 32'h0000_0000); tick();
      for (int i = 0; i < TO - 1; i++) tick();
      s0_ack_i = 1;
      #1; check("to_ack", {m_ack_o, m_err_o}, 2'b10);
      tick(); tick();
      bus(0, 0, 0, 0); tick(); tick();
      // cross-decode mid-cycle
      bus(1, 1, 0, 32'h0000_0000); tick(); tick();
      bus(1, 1, 0, 32'h0100_0000);
      #1; check("xd_stb", s1_stb_o, 1'b0);
      tick();
      check("xd_err", m_err_o, 1'b1);
      tick();
      bus(0, 0, 0, 0); tick(); tick();
      // asynchronous reset inside a slave 1 transfer
      s1_ack_i = 0;
      bus(1, 1, 0, 32'h0100_0000); tick();
      #2; check("ar_pre", {s1_cyc_o, s1_stb_o}, 2'b11);
      rst = 1'b0;
      #1; check("ar_drop", {s1_cyc_o, s1_stb_o}, 2'b00);
      model_reset();
      @(posedge clk); #1;
      bus(0, 0, 0, 0); rst = 1'b1;
      s0_int_i = 1;
      #1; check("int", m_int_o, 1'b1);
      tick();
      s0_int_i = 0; tick();
      // randomized traffic
      rate = 50;
      bus(0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] adr;
         if (c % 64 == 0) rate = $urandom_range(0, 3) * 33;
         adr = m_adr_i;
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0: adr[31:24] = 8'h00;
               1: adr[31:24] = 8'h01;
               2: adr[31:24] = 8'h05;
               default: adr[31:24] = 8'($urandom);
            endcase
         end
         adr[23:0] = 24'($urandom);
         bus(($urandom_range(0, 9) == 0) ? ~m_cyc_i : m_cyc_i, 1'b0, 1'($urandom), adr);
         m_stb_i = m_cyc_i & ($urandom_range(0, 3) != 0);
         s0_ack_i = $urandom_range(0, 99) < rate; s1_ack_i = $urandom_range(0, 99) < rate;
         s0_dat_i = $urandom; s1_dat_i = $urandom;
         s0_int_i = $urandom_range(0, 7) == 0; s1_int_i = $urandom_range(0, 7) == 0;
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/wishbone_slave_decoder_2.md
Name: wishbone_slave_decoder_2

Overview:
- Fans one Wishbone master out to two Wishbone slaves; the counterpart of the 2-master arbitrator, placed on the slave side of the bus.
- Decodes the upper address byte to pick a slave and holds that selection for the whole bus cycle (m_cyc_i high).
- Includes a no-ack watchdog and an error response for unmapped addresses, so a master can never hang.

Parameters:
S0_BASE, 8'h00, m_adr_i[31:24] value that selects slave 0
S1_BASE, 8'h01, m_adr_i[31:24] value that selects slave 1
TIMEOUT, 16'd1024, cycles with m_stb_i high and no ack before the watchdog aborts (must be >= 2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
m_we_i, m_cyc_i, m_stb_i  in  1 each  master write enable / cycle / strobe
m_sel_i  in  4  master byte selects
m_adr_i  in  32  master address
m_dat_i  in  32  master write data
m_dat_o  out  32  read data returned to the master
m_ack_o  out  1  transfer acknowledge to the master
m_err_o  out  1  error termination to the master (unmapped address or timeout)
m_int_o  out  1  interrupt to the master
s0_we_o, s0_cyc_o, s0_stb_o  out  1 each  slave 0 control
s0_sel_o  out  4;  s0_adr_o  out  32;  s0_dat_o  out  32  slave 0 select / address / write data
s0_ack_i  in  1;  s0_dat_i  in  32;  s0_int_i  in  1  slave 0 acknowledge / read data / interrupt
s1_*  identical set for slave 1

Behaviour:
- FSM states: IDLE, SEL0, SEL1, ERR, DRAIN. Also holds a 16-bit watchdog counter wd.
- Reset (rst=0, async): state=IDLE, wd=0, m_err_o=0. All s*_ outputs, m_ack_o and m_dat_o evaluate to 0.
- IDLE, when m_cyc_i & m_stb_i, decode m_adr_i[31:24]:
  - ==S0_BASE -> SEL0
  - ==S1_BASE -> SEL1
  - anything else -> ERR
  - Takes effect at the next edge, so minimum latency is 1 cycle from master stb to slave stb.
- SEL0 / SEL1 routing (combinational):
  - Selected slave receives m_we/cyc/stb/sel/dat unchanged.
  - Selected slave's s_adr_o = {8'h00, m_adr_i[23:0]}.
  - m_ack_o = selected slave's ack; m_dat_o = selected slave's dat.
  - The unselected slave sees all-zero outputs.
  - In IDLE, ERR and DRAIN, both slaves see all-zero outputs, and m_ack_o = 0, m_dat_o = 0.
- Block cycles: selection is held while m_cyc_i=1, so multiple stb/ack beats go to the same slave. When m_cyc_i=0 -> IDLE.
- Mid-cycle cross-decode: in SEL0/SEL1, if m_stb_i=1 and m_adr_i[31:24] decodes to a different slave or to an unmapped value -> ERR. Slave outputs are zeroed in that same cycle, so the access never reaches the wrong slave.
- Watchdog:
  - In SEL0/SEL1, wd increments each cycle that m_stb_i=1 and the selected ack=0.
  - wd clears to 0 on ack, on m_stb_i=0, and in every other state.
  - If wd==TIMEOUT-1 and there is no ack in that cycle -> ERR. The slave's stb/cyc drop on the transition.
  - An ack that arrives in the same cycle as wd==TIMEOUT-1 wins: the transfer completes normally.
- ERR: m_err_o is registered, high for exactly the one cycle spent in ERR; m_ack_o=0.
  - Next state is DRAIN if m_cyc_i=1, else IDLE.
- DRAIN: all outputs idle; a new m_stb_i gets no response. -> IDLE when m_cyc_i=0.
- m_int_o = s0_int_i | s1_int_i in every state, combinational, independent of selection.
- m_ack_o and m_err_o are never high in the same cycle.
- Reset during any state aborts immediately: slave cyc/stb fall asynchronously.

Test Plan:
- Single read to slave 0: m_adr=32'h00000010, stb/cyc at cycle 0; slave 0 acks in its first stb cycle with dat=32'hDEADBEEF -> s0_stb_o high at cycle 1, s0_adr_o=32'h00000010, m_ack_o=1 and m_dat_o=32'hDEADBEEF at cycle 1, s1_* all 0 throughout.
- Block write to slave 1: adr 32'h01000000..0C, 4 beats, cyc held -> 4 acks all from slave 1, s1_adr_o upper byte 8'h00, state returns to IDLE one edge after cyc falls.
- Unmapped address 32'h05000000 -> m_err_o high for exactly 1 cycle at cycle 1, no slave stb ever asserted; with cyc held the FSM stays in DRAIN and ignores a second stb.
- Timeout with TIMEOUT=16, slave 0 never acks -> m_err_o pulses once after 16 stb cycles and s0_stb_o falls on the same edge. Repeat with ack arriving exactly at wd=15 -> m_ack_o=1 and no m_err_o.
- Cross-decode in one cycle: beat 1 to 32'h00000000 acked, beat 2 to 32'h01000000 with cyc held -> s1_stb_o never asserts, m_err_o=1 for one cycle.
- Reset: assert rst=0 mid-transfer in SEL1 -> s1_cyc_o/s1_stb_o drop without waiting for clk. Separately, toggle s0_int_i in IDLE -> m_int_o follows it in the same cycle.
